// File: rtl/vga_dither_out.sv
// Final pixel stage: 4x4 ordered dither of 8-bit RGB down to 3/3/2, switch mask,
// blanking, and a 3-strobe sync delay that stays aligned with the colour path.
module vga_dither_out #(
  parameter bit DITHER_EN   = 1'b1,
  parameter bit TEMPORAL_EN = 1'b1,
  parameter bit SYNC_IDLE   = 1'b1
) (
  input  logic       clk100,
  input  logic       rst_n,
  input  logic       pix_stb,
  input  logic       i_active,
  input  logic       i_hs,
  input  logic       i_vs,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  input  logic [7:0] sw,
  output logic [2:0] vga_red,
  output logic [2:0] vga_green,
  output logic [1:0] vga_blue,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic [1:0] o_frame
);

  logic [7:0] s1_r_q, s1_g_q, s1_b_q;
  logic [1:0] s1_x_q, s1_y_q;
  logic       s1_act_q, s1_hs_q, s1_vs_q;
  logic       armed_q;
  logic [1:0] frame_q, frame_d;

  logic [2:0] s2_r_q, s2_g_q, s2_r_d, s2_g_d;
  logic [1:0] s2_b_q, s2_b_d;
  logic       s2_act_q, s2_hs_q, s2_vs_q;

  logic [2:0] red_q, green_q, red_d, green_d;
  logic [1:0] blue_q, blue_d;
  logic       hs_q, vs_q;

  logic [1:0] col, row;
  logic [3:0] bayer;
  logic [8:0] sum_r, sum_g, sum_b;
  logic       unused_coord;

  assign unused_coord = ^{i_x[9:2], i_y[8:2]};

  function automatic logic [3:0] bayer_lut(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] v;
    case ({r, c})
      4'h0: v = 4'd0;   4'h1: v = 4'd8;   4'h2: v = 4'd2;   4'h3: v = 4'd10;
      4'h4: v = 4'd12;  4'h5: v = 4'd4;   4'h6: v = 4'd14;  4'h7: v = 4'd6;
      4'h8: v = 4'd3;   4'h9: v = 4'd11;  4'hA: v = 4'd1;   4'hB: v = 4'd9;
      4'hC: v = 4'd15;  4'hD: v = 4'd7;   4'hE: v = 4'd13;  default: v = 4'd5;
    endcase
    return v;
  endfunction

  // Threshold add in 9 bits; a carry saturates the channel to 255 before truncation.
  always_comb begin
    col = s1_x_q;
    row = s1_y_q;
    if (TEMPORAL_EN) begin
      col = s1_x_q ^ frame_q;
      row = s1_y_q ^ {frame_q[0], frame_q[1]};
    end
    bayer  = DITHER_EN ? bayer_lut(row, col) : 4'd0;
    sum_r  = {1'b0, s1_r_q} + {4'd0, bayer, 1'b0};
    sum_g  = {1'b0, s1_g_q} + {4'd0, bayer, 1'b0};
    sum_b  = {1'b0, s1_b_q} + {3'd0, bayer, 2'b00};
    s2_r_d = sum_r[8] ? 3'd7 : sum_r[7:5];
    s2_g_d = sum_g[8] ? 3'd7 : sum_g[7:5];
    s2_b_d = sum_b[8] ? 2'd3 : sum_b[7:6];
  end

  always_comb begin
    red_d   = s2_act_q ? (s2_r_q & sw[7:5]) : 3'd0;
    green_d = s2_act_q ? (s2_g_q & sw[4:2]) : 3'd0;
    blue_d  = s2_act_q ? (s2_b_q & sw[1:0]) : 2'd0;
  end

  // armed_q keeps a vs edge on the very first strobe after reset from counting.
  always_comb begin
    frame_d = frame_q;
    if (armed_q && s1_vs_q && !i_vs) frame_d = frame_q + 2'd1;
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      s1_r_q   <= 8'd0;
      s1_g_q   <= 8'd0;
      s1_b_q   <= 8'd0;
      s1_x_q   <= 2'd0;
      s1_y_q   <= 2'd0;
      s1_act_q <= 1'b0;
      s1_hs_q  <= SYNC_IDLE;
      s1_vs_q  <= SYNC_IDLE;
      armed_q  <= 1'b0;
      frame_q  <= 2'd0;
      s2_r_q   <= 3'd0;
      s2_g_q   <= 3'd0;
      s2_b_q   <= 2'd0;
      s2_act_q <= 1'b0;
      s2_hs_q  <= SYNC_IDLE;
      s2_vs_q  <= SYNC_IDLE;
      red_q    <= 3'd0;
      green_q  <= 3'd0;
      blue_q   <= 2'd0;
      hs_q     <= SYNC_IDLE;
      vs_q     <= SYNC_IDLE;
    end else if (pix_stb) begin
      s1_r_q   <= i_r;
      s1_g_q   <= i_g;
      s1_b_q   <= i_b;
      s1_x_q   <= i_x[1:0];
      s1_y_q   <= i_y[1:0];
      s1_act_q <= i_active;
      s1_hs_q  <= i_hs;
      s1_vs_q  <= i_vs;
      armed_q  <= 1'b1;
      frame_q  <= frame_d;
      s2_r_q   <= s2_r_d;
      s2_g_q   <= s2_g_d;
      s2_b_q   <= s2_b_d;
      s2_act_q <= s1_act_q;
      s2_hs_q  <= s1_hs_q;
      s2_vs_q  <= s1_vs_q;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
      hs_q     <= s2_hs_q;
      vs_q     <= s2_vs_q;
    end
  end

  assign vga_red   = red_q;
  assign vga_green = green_q;
  assign vga_blue  = blue_q;
  assign vga_hs    = hs_q;
  assign vga_vs    = vs_q;
  assign o_frame   = frame_q;

endmodule

// File: tb/tb_vga_dither_out.sv
// Bench for vga_dither_out: per-strobe history arrays feed an arithmetic reference
// model; a second instance covers the undithered build.
module tb_vga_dither_out;
  logic       clk100 = 1'b0;
  logic       rst_n = 1'b1;
  logic       pix_stb = 1'b0;
  logic       i_active = 1'b0, i_hs = 1'b1, i_vs = 1'b1;
  logic [9:0] i_x = '0;
  logic [8:0] i_y = '0;
  logic [7:0] i_r = '0, i_g = '0, i_b = '0, sw = 8'hFF;
  logic [2:0] vga_red, vga_green, nd_red, nd_green;
  logic [1:0] vga_blue, nd_blue, o_frame, nd_frame;
  logic       vga_hs, vga_vs, nd_hs, nd_vs;

  vga_dither_out dut (
    .clk100(clk100), .rst_n(rst_n), .pix_stb(pix_stb), .i_active(i_active),
    .i_hs(i_hs), .i_vs(i_vs), .i_x(i_x), .i_y(i_y), .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .sw(sw), .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .o_frame(o_frame));

  vga_dither_out #(.DITHER_EN(1'b0), .TEMPORAL_EN(1'b0)) dut_nd (
    .clk100(clk100), .rst_n(rst_n), .pix_stb(pix_stb), .i_active(i_active),
    .i_hs(i_hs), .i_vs(i_vs), .i_x(i_x), .i_y(i_y), .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .sw(sw), .vga_red(nd_red), .vga_green(nd_green), .vga_blue(nd_blue),
    .vga_hs(nd_hs), .vga_vs(nd_vs), .o_frame(nd_frame));

  always #5 clk100 = ~clk100;

  int checks = 0;
  int errors = 0;

  logic       d_act = 1'b0, d_hs = 1'b1, d_vs = 1'b1;
  logic [9:0] d_x = '0;
  logic [8:0] d_y = '0;
  logic [7:0] d_r = '0, d_g = '0, d_b = '0, d_sw = 8'hFF;

  int   nstb = 0;
  int   mframe = 0;
  int   h_r [4096], h_g [4096], h_b [4096], h_x [4096], h_y [4096], h_frm [4096];
  bit   h_act [4096], h_hs [4096], h_vs [4096];
  logic [7:0] h_sw [4096];
  int   bayer [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

  // One pixel period: strobe for one clock, then three idle clocks with junk on the inputs.
  task automatic strobe();
    @(negedge clk100);
    pix_stb = 1'b1;
    i_r = d_r; i_g = d_g; i_b = d_b; i_x = d_x; i_y = d_y;
    i_active = d_act; i_hs = d_hs; i_vs = d_vs; sw = d_sw;
    if (rst_n && nstb < 4096) begin
      h_r[nstb] = d_r; h_g[nstb] = d_g; h_b[nstb] = d_b;
      h_x[nstb] = int'(d_x); h_y[nstb] = int'(d_y);
      h_act[nstb] = d_act; h_hs[nstb] = d_hs; h_vs[nstb] = d_vs; h_sw[nstb] = d_sw;
      if (nstb >= 1 && h_vs[nstb-1] && !d_vs) mframe = (mframe + 1) % 4;
      h_frm[nstb] = mframe;
      nstb++;
    end
    @(negedge clk100);
    pix_stb = 1'b0;
    i_r = 8'($urandom); i_g = 8'($urandom); i_b = 8'($urandom);
    i_x = 10'($urandom); i_y = 9'($urandom); sw = 8'($urandom);
    i_active = 1'($urandom); i_hs = 1'($urandom); i_vs = 1'($urandom);
    @(negedge clk100);
    @(negedge clk100);
  endtask

  task automatic do_reset();
    @(negedge clk100);
    rst_n = 1'b0;
    repeat (3) @(negedge clk100);
    rst_n = 1'b1;
    nstb = 0;
    mframe = 0;
  endtask

  // Expected {red, green, blue, hs, vs} after strobe k (counted from reset release).
  function automatic logic [9:0] model(int k, bit dith, bit temp);
    int j, f, c, rw, bv, rr, gg, bb;
    logic [7:0] s;
    logic [2:0] er, eg;
    logic [1:0] eb;
    if (k < 2) return {8'd0, 1'b1, 1'b1};
    j  = k - 2;
    f  = temp ? h_frm[j] : 0;
    c  = (h_x[j] % 4) ^ f;
    rw = (h_y[j] % 4) ^ (((f & 1) << 1) | (f >> 1));
    bv = dith ? bayer[rw][c] : 0;
    rr = h_r[j] + 2 * bv; if (rr > 255) rr = 255;
    gg = h_g[j] + 2 * bv; if (gg > 255) gg = 255;
    bb = h_b[j] + 4 * bv; if (bb > 255) bb = 255;
    s  = h_sw[k];
    er = h_act[j] ? (3'(rr / 32) & s[7:5]) : 3'd0;
    eg = h_act[j] ? (3'(gg / 32) & s[4:2]) : 3'd0;
    eb = h_act[j] ? (2'(bb / 64) & s[1:0]) : 2'd0;
    return {er, eg, eb, h_hs[j], h_vs[j]};
  endfunction

  task automatic set_pix(input int r, input int g, input int b, input int x, input int y,
                         input bit act);
    d_r = 8'(r); d_g = 8'(g); d_b = 8'(b); d_x = 10'(x); d_y = 9'(y); d_act = act;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk100);
    got = {vga_red, vga_green, vga_blue, vga_hs, vga_vs, o_frame};
    checks++;
    if (got !== 12'b000_000_00_1_1_00) begin
      errors++; $display("FAIL reset_initial got=%b want=%b", got, 12'b000_000_00_1_1_00);
    end
    @(negedge clk100) rst_n = 1'b1;
    nstb = 0; mframe = 0;
    d_sw = 8'hFF; d_hs = 1'b1;
    set_pix(255, 255, 255, 1, 2, 1'b1);
    d_vs = 1'b1; strobe(); d_vs = 1'b0; strobe();
    d_vs = 1'b1; strobe(); d_vs = 1'b0; strobe();
    checks++;
    if ({vga_red, vga_green, vga_blue, o_frame} !== {3'd7, 3'd7, 2'd3, 2'd2}) begin
      errors++; $display("FAIL reset_prep got=%0d/%0d/%0d f%0d want=7/7/3 f2",
                         vga_red, vga_green, vga_blue, o_frame);
    end
    @(negedge clk100) pix_stb = 1'b1;
    @(posedge clk100);
    #2 rst_n = 1'b0;
    #1 got = {vga_red, vga_green, vga_blue, vga_hs, vga_vs, o_frame};
    checks++;
    if (got !== 12'b000_000_00_1_1_00) begin
      errors++; $display("FAIL reset_async got=%b want=%b", got, 12'b000_000_00_1_1_00);
    end
    repeat (3) begin
      @(negedge clk100) pix_stb = 1'b0;
      @(negedge clk100) pix_stb = 1'b1;
    end
    @(negedge clk100) pix_stb = 1'b0;
    rst_n = 1'b1;
    nstb = 0; mframe = 0;
    d_vs = 1'b1;
    for (int k = 0; k < 3; k++) begin
      strobe();
      checks++;
      if (k < 2 && {vga_red, vga_green, vga_blue, vga_hs, vga_vs} !== 10'b000_000_00_1_1) begin
        errors++; $display("FAIL reset_latency_early k=%0d got=%0d/%0d/%0d want=0/0/0",
                           k, vga_red, vga_green, vga_blue);
      end
      if (k == 2 && {vga_red, vga_green, vga_blue} !== {3'd7, 3'd7, 2'd3}) begin
        errors++; $display("FAIL reset_latency_first got=%0d/%0d/%0d want=7/7/3",
                           vga_red, vga_green, vga_blue);
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] e, en;
    for (int n = 0; n < 200; n++) begin
      set_pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 1023), $urandom_range(0, 511), 1'($urandom));
      d_hs = ($urandom_range(0, 7) != 0);
      d_vs = ($urandom_range(0, 5) != 0);
      d_sw = 8'($urandom);
      strobe();
      e  = model(nstb - 1, 1'b1, 1'b1);
      en = model(nstb - 1, 1'b0, 1'b0);
      checks++;
      if ({vga_red, vga_green, vga_blue, vga_hs, vga_vs} !== e) begin
        errors++; $display("FAIL random_out n=%0d got=%b want=%b", n,
                           {vga_red, vga_green, vga_blue, vga_hs, vga_vs}, e);
      end
      checks++;
      if (o_frame !== 2'(mframe)) begin
        errors++; $display("FAIL random_frame n=%0d got=%0d want=%0d", n, o_frame, mframe);
      end
      checks++;
      if ({nd_red, nd_green, nd_blue, nd_hs, nd_vs} !== en) begin
        errors++; $display("FAIL random_nodither n=%0d got=%b want=%b", n,
                           {nd_red, nd_green, nd_blue, nd_hs, nd_vs}, en);
      end
    end
    d_sw = 8'hFF; d_hs = 1'b1; d_vs = 1'b1;
  endtask

  task automatic test_latency();
    logic want;
    d_vs = 1'b1;
    for (int rel = 0; rel < 115; rel++) begin
      set_pix($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              rel, 0, 1'b1);
      d_hs = !(rel >= 10 && rel < 106);
      strobe();
      want = !(rel >= 12 && rel <= 107);
      if (rel >= 2) begin
        checks++;
        if (vga_hs !== want) begin
          errors++; $display("FAIL latency_hs strobe=%0d got=%b want=%b", rel, vga_hs, want);
        end
      end
    end
    d_hs = 1'b1;
  endtask

  task automatic test_dither_values();
    int tr [3] = '{20, 20, 0};
    int tb [3] = '{0, 0, 200};
    int tx [3] = '{1, 0, 0};
    int ty [3] = '{0, 0, 3};
    int er [3] = '{1, 0, 0};
    int eb [3] = '{0, 0, 3};
    do_reset();
    d_vs = 1'b1; d_sw = 8'hFF;
    for (int t = 0; t < 3; t++) begin
      set_pix(tr[t], tr[t], tb[t], tx[t], ty[t], 1'b1);
      strobe();
      set_pix(0, 0, 0, 0, 0, 1'b0);
      strobe(); strobe();
      checks++;
      if (vga_red !== 3'(er[t]) || vga_green !== 3'(er[t]) || vga_blue !== 2'(eb[t])) begin
        errors++; $display("FAIL dither_value t=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", t,
                           vga_red, vga_green, vga_blue, er[t], er[t], eb[t]);
      end
    end
  endtask

  task automatic test_sat_mask();
    d_sw = 8'hFF; d_vs = 1'b1;
    for (int i = 0; i < 18; i++) begin
      set_pix(255, 255, 255, i % 4, (i / 4) % 4, 1'b1);
      strobe();
      if (i >= 2) begin
        checks++;
        if ({vga_red, vga_green, vga_blue} !== {3'd7, 3'd7, 2'd3}) begin
          errors++; $display("FAIL sat_white pos=%0d got=%0d/%0d/%0d want=7/7/3", i - 2,
                             vga_red, vga_green, vga_blue);
        end
      end
    end
    d_sw = 8'b101_010_01;
    strobe();
    checks++;
    if ({vga_red, vga_green, vga_blue} !== {3'd5, 3'd2, 2'd1}) begin
      errors++; $display("FAIL sat_mask got=%0d/%0d/%0d want=5/2/1", vga_red, vga_green, vga_blue);
    end
    d_sw = 8'hFF;
    d_act = 1'b0;
    strobe(); strobe(); strobe();
    checks++;
    if ({vga_red, vga_green, vga_blue, nd_red, nd_green, nd_blue} !== 16'd0) begin
      errors++; $display("FAIL sat_blank got=%0d/%0d/%0d want=0/0/0", vga_red, vga_green, vga_blue);
    end
  endtask

  task automatic test_temporal();
    int seq [5] = '{1, 2, 3, 0, 1};
    do_reset();
    d_sw = 8'hFF;
    set_pix(0, 0, 0, 0, 0, 1'b0);
    d_vs = 1'b1; strobe();
    for (int e = 0; e < 5; e++) begin
      d_vs = 1'b1; strobe();
      d_vs = 1'b0; strobe();
      checks++;
      if (o_frame !== 2'(seq[e])) begin
        errors++; $display("FAIL temporal_frame edge=%0d got=%0d want=%0d", e, o_frame, seq[e]);
      end
    end
    set_pix(10, 10, 0, 0, 0, 1'b1);
    strobe();
    set_pix(0, 0, 0, 0, 0, 1'b0);
    strobe(); strobe();
    checks++;
    if (vga_red !== 3'd1 || nd_red !== 3'd0) begin
      errors++; $display("FAIL temporal_pixel got=%0d nd=%0d want=1 nd=0", vga_red, nd_red);
    end
    d_vs = 1'b1;
  endtask

  task automatic test_no_dither();
    int r;
    d_sw = 8'hFF; d_vs = 1'b1;
    for (int t = 0; t < 4; t++) begin
      r = (t % 2 == 0) ? 31 : 32;
      set_pix(r, r, 0, $urandom_range(0, 1023), $urandom_range(0, 511), 1'b1);
      strobe();
      set_pix(0, 0, 0, 0, 0, 1'b0);
      strobe(); strobe();
      checks++;
      if (nd_red !== 3'(r / 32) || nd_green !== 3'(r / 32)) begin
        errors++; $display("FAIL no_dither t=%0d r=%0d got=%0d/%0d want=%0d", t, r,
                           nd_red, nd_green, r / 32);
      end
    end
  endtask

  initial begin
    test_reset();
    test_random();
    test_latency();
    test_dither_values();
    test_sat_mask();
    test_temporal();
    test_no_dither();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
